pipe_adder: RTL and testbench
=============================

// Module: pipe_adder
// PURPOSE
//   Parametrised pipelined carry-chain adder/subtractor, successor to the fixed 4-bit ripple adder.
//   Splits a WIDTH-bit operation into STAGES = WIDTH/SEG_W segments.
//   One segment is resolved per clock, with the segment carry registered between stages.
//   Sits between datapath producers and consumers behind a valid/ready handshake; accepts one operation per cycle.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be an integer multiple of SEG_W
//   SEG_W   8  bits resolved per pipeline stage (1..WIDTH)
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      synchronous reset, active-low
//   in_valid   in   1      operands/ci/sub valid this cycle
//   in_ready   out  1      block can accept an operation this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   ci         in   1      carry-in (ignored when sub=1)
//   sub        in   1      0: a+b+ci; 1: a-b (a + ~b + 1)
//   out_valid  out  1      so/co valid
//   out_ready  in   1      consumer accepts result
//   so         out  WIDTH  result, modulo 2^WIDTH
//   co         out  1      carry-out of MSB (sub=1: 1 means no borrow, i.e. a>=b unsigned)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - all stage valid bits, out_valid, so, co cleared to 0; in_ready=1 on the following cycle.
//   - Operations in flight are discarded, not completed.
// - Accept rule: transfer when in_valid && in_ready.
//   - Stage-0 captures a, b (b inverted when sub=1) and the effective carry-in (sub ? 1 : ci).
// - Stage k (0..STAGES-1):
//   - adds segment k of the skewed operands plus the carry registered by stage k-1.
//   - Registers the partial sum and the new carry.
//   - Upper, not-yet-used operand segments travel alongside; lower result segments are delayed so so emerges aligned.
// - Latency: exactly STAGES cycles from accept to out_valid with no stall.
//   - WIDTH=32, SEG_W=8 gives 4 cycles.
//   - SEG_W=WIDTH gives 1 cycle, a single registered adder.
// - Throughput: one operation per cycle; results leave in acceptance order.
// - Backpressure: global stall.
//   - in_ready = !out_valid || out_ready.
//   - When out_valid && !out_ready, every stage holds: so/co stable, no new accept.
//   - Bubbles are not compressed.
// - Bubbles: cycles without accept propagate a 0 valid bit; out_valid drops for exactly those slots.
// - Simultaneous accept and output consume in one cycle is allowed; pipeline advances one slot.
// - so/co keep their last value while out_valid=0; they are not cleared except by reset.
// - Arithmetic wraps modulo 2^WIDTH; no saturation. Full-width result is so concatenated below co ({co,so}).
// - Operands are sampled only at accept; later changes of a/b/ci/sub have no effect on in-flight data.
// CONFIGURATION
//   Macro: PIPE_ADDER_OVF_EN
//   - Defined: adds output port ovf (out, 1).
//     - Signed two's-complement overflow of the operation = carry into MSB XOR carry out of MSB.
//     - Aligned with so/co; reset 0; held under stall like so.
//   - Not defined: port ovf absent, no overflow logic generated; all other behaviour identical.
// TESTING (WIDTH=32, SEG_W=8 unless noted)
//   1. Carry across all segments:
//      a=32'hFFFF_FFFF, b=0, ci=1, sub=0 -> 4 cycles later so=32'h0, co=1, out_valid=1 for one cycle.
//   2. Subtract:
//      a=100, b=58, sub=1 -> so=42, co=1.
//      a=5, b=7, sub=1 -> so=32'hFFFF_FFFE, co=0.
//   3. Back-to-back streaming:
//      issue 8 consecutive ops (a=i, b=i<<24), out_ready=1 -> 8 consecutive out_valid cycles, in order, each so=i+(i<<24).
//   4. Backpressure:
//      stream 6 ops, drop out_ready for 3 cycles at first result -> in_ready=0 those cycles, so held, no op lost or duplicated.
//   5. Reset mid-flight:
//      accept 3 ops, assert rst_n=0 at cycle 2 -> next cycle out_valid=0, so=0, co=0; no stale result ever appears.
//   6. PIPE_ADDER_OVF_EN defined:
//      a=32'h7FFF_FFFF, b=1 -> ovf=1, so=32'h8000_0000.
//      Repeat with SEG_W=32 -> same result after 1 cycle.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined segmented carry-chain adder/subtractor.
// WIDTH bits are resolved SEG_W bits per clock over WIDTH/SEG_W stages,
// with the segment carry registered between stages. A global stall freezes
// every stage while the result is held at the output.
// Optional feature macro: PIPE_ADDER_OVF_EN adds the signed overflow output ovf.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] so,
  output logic             co
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / SEG_W;
  localparam int LAST   = STAGES - 1;

  logic w_adv;

  // Each stage owns one segment. Operand bits above the current segment ride
  // along in r_a/r_b (shrinking per stage); finished result bits accumulate
  // in r_sum (growing per stage) so the full sum leaves the last stage aligned.
  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int LO  = k * SEG_W;
    localparam int REM = WIDTH - LO;

    logic                w_vld_in;
    logic                w_c_in;
    logic [REM-1:0]      w_a_in;
    logic [REM-1:0]      w_b_in;
    logic [SEG_W:0]      w_seg;
    logic [LO+SEG_W-1:0] w_sum_nx;

    logic                r_vld;
    logic                r_cy;
    logic [LO+SEG_W-1:0] r_sum;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1: invert b here and force the carry-in.
      assign w_vld_in = in_valid;
      assign w_a_in   = a;
      assign w_b_in   = sub ? ~b : b;
      assign w_c_in   = sub | ci;
      assign w_sum_nx = w_seg[SEG_W-1:0];
    end else begin : g_body
      assign w_vld_in = gen_stage[k-1].r_vld;
      assign w_a_in   = gen_stage[k-1].g_ops.r_a;
      assign w_b_in   = gen_stage[k-1].g_ops.r_b;
      assign w_c_in   = gen_stage[k-1].r_cy;
      assign w_sum_nx = {w_seg[SEG_W-1:0], gen_stage[k-1].r_sum};
    end

    assign w_seg = {1'b0, w_a_in[SEG_W-1:0]} + {1'b0, w_b_in[SEG_W-1:0]}
                 + {{SEG_W{1'b0}}, w_c_in};

    // Stage valid/carry/partial-sum register; data only loads on a valid slot
    // so the output keeps its last result through bubbles.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld_in;
        if (w_vld_in) begin
          r_cy  <= w_seg[SEG_W];
          r_sum <= w_sum_nx;
        end
      end
    end

    if (k < LAST) begin : g_ops
      logic [REM-SEG_W-1:0] r_a;
      logic [REM-SEG_W-1:0] r_b;

      // Carry the not-yet-used upper operand segments to the next stage.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vld_in) begin
          r_a <= w_a_in[REM-1:SEG_W];
          r_b <= w_b_in[REM-1:SEG_W];
        end
      end
    end

`ifdef PIPE_ADDER_OVF_EN
    if (k == LAST) begin : g_ovf
      logic r_ovf;

      // Carry into the MSB is recovered as a^b^sum at the MSB; xor with carry-out.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_vld_in) begin
          r_ovf <= w_a_in[SEG_W-1] ^ w_b_in[SEG_W-1] ^ w_seg[SEG_W-1] ^ w_seg[SEG_W];
        end
      end
    end
`endif
  end

  assign out_valid = gen_stage[LAST].r_vld;
  assign so        = gen_stage[LAST].r_sum;
  assign co        = gen_stage[LAST].r_cy;
`ifdef PIPE_ADDER_OVF_EN
  assign ovf       = gen_stage[LAST].g_ovf.r_ovf;
`endif

  // Global stall: the whole pipe advances only when the output slot is free
  // or being consumed.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: a slot-level reference model of the 4-stage pipe
// checked every cycle, plus directed vectors with literal expectations and a
// second instance with SEG_W=WIDTH (single registered adder).
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ci = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] so;
  logic        co;
  logic        ovf;

  logic        p_in_valid = 1'b0;
  logic [31:0] p_a = '0;
  logic [31:0] p_b = '0;
  logic        p_ci = 1'b0;
  logic        p_sub = 1'b0;
  logic        p_out_ready = 1'b1;
  logic        p_in_ready;
  logic        p_out_valid;
  logic [31:0] p_so;
  logic        p_co;
  logic        p_ovf;

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic [31:0] q_got[$];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(32), .SEG_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .so(so), .co(co)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipe_adder #(.WIDTH(32), .SEG_W(32)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .ci(p_ci), .sub(p_sub), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .so(p_so), .co(p_co)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(p_ovf)
`endif
  );

`ifndef PIPE_ADDER_OVF_EN
  assign ovf   = 1'b0;
  assign p_ovf = 1'b0;
`endif

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  // {co,so} of the operation as plain arithmetic.
  function automatic logic [32:0] ref_sum(input logic [31:0] x, y, input logic c, s);
    if (s) return {1'b0, x} + 33'h1_0000_0000 - {1'b0, y};
    return {1'b0, x} + {1'b0, y} + {32'b0, c};
  endfunction

  // Signed overflow: the exact integer result does not fit in 32-bit signed.
  function automatic logic ref_ovf(input logic [31:0] x, y, input logic c, s);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = s ? (sx - sy) : (sx + sy + longint'(c));
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Reference model: four slots that all move together when the output slot
  // is free or consumed; output value is held until a valid slot arrives.
  logic        m_vld[4];
  logic [32:0] m_res[4];
  logic        m_ov[4];
  logic [31:0] m_so;
  logic        m_co;
  logic        m_ovf;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_vld[i] <= 1'b0;
      m_so  <= '0;
      m_co  <= 1'b0;
      m_ovf <= 1'b0;
    end else if (!m_vld[3] || out_ready) begin
      if (m_vld[2]) begin
        m_so  <= m_res[2][31:0];
        m_co  <= m_res[2][32];
        m_ovf <= m_ov[2];
      end
      for (int i = 3; i > 0; i--) begin
        m_vld[i] <= m_vld[i-1];
        m_res[i] <= m_res[i-1];
        m_ov[i]  <= m_ov[i-1];
      end
      m_vld[0] <= in_valid;
      m_res[0] <= ref_sum(a, b, ci, sub);
      m_ov[0]  <= ref_ovf(a, b, ci, sub);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("model out_valid", out_valid, m_vld[3]);
      check("model in_ready", in_ready, !m_vld[3] || out_ready);
      check("model so", so, m_so);
      check("model co", co, m_co);
`ifdef PIPE_ADDER_OVF_EN
      check("model ovf", ovf, m_ovf);
`endif
      if (out_valid && out_ready) q_got.push_back(so);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one op until accepted; afterwards scramble the inputs so any
  // late sampling of operands would show up as a wrong result.
  task automatic issue(input logic [31:0] aa, bb, input logic cc, ss);
    logic acc;
    int g;
    a = aa; b = bb; ci = cc; sub = ss; in_valid = 1'b1;
    g = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      sync();
      g++;
    end while (!acc && g < 50);
    check("issue accepted", acc, 1'b1);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_out(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({nm, " latency"}, lat, exp_lat);
  endtask

  task automatic expect_cycle(input string nm, input logic v, input logic [31:0] s);
    @(negedge clk);
    check({nm, " out_valid"}, out_valid, v);
    if (v) check({nm, " so"}, so, s);
    sync();
  endtask

  task automatic one_op(input string nm, input logic [31:0] aa, bb, input logic cc, ss,
                        input logic [31:0] es, input logic ec, eo);
    p_a = aa; p_b = bb; p_ci = cc; p_sub = ss; p_in_valid = 1'b1;
    @(negedge clk);
    check({nm, " in_ready"}, p_in_ready, 1'b1);
    sync();
    p_in_valid = 1'b0;
    p_a = $urandom; p_b = $urandom;
    @(negedge clk);
    check({nm, " out_valid"}, p_out_valid, 1'b1);
    check({nm, " so"}, p_so, es);
    check({nm, " co"}, p_co, ec);
`ifdef PIPE_ADDER_OVF_EN
    check({nm, " ovf"}, p_ovf, eo);
`else
    if (eo) check({nm, " ovf unused"}, p_ovf, 1'b0);
`endif
    sync();
    @(negedge clk);
    check({nm, " drop"}, p_out_valid, 1'b0);
    check({nm, " held"}, p_so, es);
    sync();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset out_valid", out_valid, 1'b0);
    check("reset so", so, 32'h0);
    check("reset co", co, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    sync();

    // Carry rippling through every segment
    issue(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    wait_out("t1", 4);
    check("t1 so", so, 32'h0);
    check("t1 co", co, 1'b1);
    sync();
    @(negedge clk);
    check("t1 single pulse", out_valid, 1'b0);
    sync();

    // Subtraction, with and without borrow; ci ignored when sub=1
    issue(32'd100, 32'd58, 1'b0, 1'b1);
    wait_out("t2a", 4);
    check("t2a so", so, 32'd42);
    check("t2a co", co, 1'b1);
    sync();
    issue(32'd5, 32'd7, 1'b1, 1'b1);
    wait_out("t2b", 4);
    check("t2b so", so, 32'hFFFF_FFFE);
    check("t2b co", co, 1'b0);
    sync();
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    wait_out("t2c", 4);
    check("t2c so", so, 32'h2222_2222);
    check("t2c co", co, 1'b0);
    sync();

    // Back-to-back streaming
    q_got.delete();
    for (int i = 0; i < 8; i++) issue(32'(i), 32'(i) << 24, 1'b0, 1'b0);
    repeat (8) sync();
    check("t3 count", q_got.size(), 8);
    for (int i = 0; i < 8; i++)
      check("t3 order", (i < q_got.size()) ? q_got[i] : 32'hDEAD_BEEF,
            32'(i) + (32'(i) << 24));

    // Bubble between two ops shows up as one empty output slot
    issue(32'd1, 32'd2, 1'b0, 1'b0);
    sync();
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    expect_cycle("bub c3", 1'b0, 32'h0);
    expect_cycle("bub c4", 1'b1, 32'd3);
    expect_cycle("bub c5", 1'b0, 32'h0);
    expect_cycle("bub c6", 1'b1, 32'd7);

    // Backpressure: 3 stalled cycles at the first result
    q_got.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) issue(32'(i * 3 + 1), 32'(i * 1000), 1'b0, 1'b0);
      end
      begin
        int g;
        g = 0;
        do begin
          sync();
          g++;
        end while (!out_valid && g < 50);
        check("t4 first result", out_valid, 1'b1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("t4 stall in_ready", in_ready, 1'b0);
          check("t4 stall so", so, 32'd1);
          sync();
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) sync();
    check("t4 count", q_got.size(), 6);
    for (int i = 0; i < 6; i++)
      check("t4 order", (i < q_got.size()) ? q_got[i] : 32'hDEAD_BEEF, 32'(1003 * i + 1));

    // Reset with three ops in flight
    q_got.delete();
    issue(32'd11, 32'd22, 1'b0, 1'b0);
    issue(32'd33, 32'd44, 1'b0, 1'b0);
    a = 32'd55; b = 32'd66; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5 out_valid", out_valid, 1'b0);
    check("t5 so", so, 32'h0);
    check("t5 co", co, 1'b0);
    check("t5 in_ready", in_ready, 1'b1);
    sync();
    repeat (10) sync();
    check("t5 no stale", q_got.size(), 0);

`ifdef PIPE_ADDER_OVF_EN
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_out("t6", 4);
    check("t6 so", so, 32'h8000_0000);
    check("t6 ovf", ovf, 1'b1);
    sync();
`endif

    // Single-stage instance: one cycle latency
    one_op("one a", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    one_op("one b", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    one_op("one c", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    one_op("one d", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
